// File: rtl/fpu_ss_offload_buffer_pkg.sv
// Package for the FPU subsystem offload buffer.
// Shared constants: FP register file size and index width, number of FP
// source operands, and default integer operand geometry. offload_entry_t
// is the default-geometry layout of one buffered offload request.
package fpu_ss_pkg;

    localparam int unsigned NUM_FPR        = 32;
    localparam int unsigned FPR_IDX_W      = $clog2(NUM_FPR);
    localparam int unsigned NUM_FPR_RS     = 3;
    localparam int unsigned XLEN_DEFAULT   = 32;
    localparam int unsigned NUM_RS_DEFAULT = 3;

    typedef logic [FPR_IDX_W-1:0] fpr_idx_t;

    typedef struct packed {
        logic [31:0]                                  instr;
        logic [NUM_RS_DEFAULT-1:0][XLEN_DEFAULT-1:0]  rs;
        fpr_idx_t [NUM_FPR_RS-1:0]                    fpr_rs;
        logic [NUM_FPR_RS-1:0]                        fpr_rs_use;
        fpr_idx_t                                     rd;
        logic                                         rd_is_fp;
    } offload_entry_t;

endpackage

// File: rtl/fpu_ss_offload_buffer_if.sv
// Bus interface of the offload buffer.
// master: request producer / issue stage / writeback side (the environment).
// slave : the buffer itself.
// Signals: flush_i; in_* request channel with in_ready_o; out_* head entry
// with out_ready_i; wb_valid_i/wb_rd_i FP writeback; usage_o occupancy.
interface fpu_ss_offload_buffer_if
    import fpu_ss_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned NUM_RS = NUM_RS_DEFAULT
);
    localparam int unsigned USAGE_W = $clog2(DEPTH + 1);

    logic                            flush_i;
    logic                            in_valid_i;
    logic                            in_ready_o;
    logic [31:0]                     in_instr_i;
    logic [NUM_RS-1:0][XLEN-1:0]     in_rs_i;
    fpr_idx_t [NUM_FPR_RS-1:0]       in_fpr_rs_i;
    logic [NUM_FPR_RS-1:0]           in_fpr_rs_use_i;
    fpr_idx_t                        in_rd_i;
    logic                            in_rd_is_fp_i;
    logic                            out_valid_o;
    logic                            out_ready_i;
    logic [31:0]                     out_instr_o;
    logic [NUM_RS-1:0][XLEN-1:0]     out_rs_o;
    fpr_idx_t                        out_rd_o;
    logic                            out_rd_is_fp_o;
    logic                            wb_valid_i;
    fpr_idx_t                        wb_rd_i;
    logic [USAGE_W-1:0]              usage_o;

    modport master (
        output flush_i, in_valid_i, in_instr_i, in_rs_i, in_fpr_rs_i,
               in_fpr_rs_use_i, in_rd_i, in_rd_is_fp_i, out_ready_i,
               wb_valid_i, wb_rd_i,
        input  in_ready_o, out_valid_o, out_instr_o, out_rs_o, out_rd_o,
               out_rd_is_fp_o, usage_o
    );

    modport slave (
        input  flush_i, in_valid_i, in_instr_i, in_rs_i, in_fpr_rs_i,
               in_fpr_rs_use_i, in_rd_i, in_rd_is_fp_i, out_ready_i,
               wb_valid_i, wb_rd_i,
        output in_ready_o, out_valid_o, out_instr_o, out_rs_o, out_rd_o,
               out_rd_is_fp_o, usage_o
    );

endinterface

// File: rtl/fpu_ss_offload_buffer_scoreboard.sv
// FP register scoreboard (module fpu_ss_scoreboard).
// Tracks one pending bit per FP register: set when an instruction with an
// FP destination issues, cleared when that register is written back. Flags a
// hazard on the presented head entry if any used FP source or its FP
// destination is still pending. Only instantiated with FPU_SS_SCOREBOARD_EN.
// Ports: clk_i, rst_i (async, active high); set_valid/set_idx (issue);
// clr_valid/clr_idx (writeback); fpr_rs/fpr_rs_use/rd/rd_is_fp (head
// entry); hazard (head must be held back).
module fpu_ss_scoreboard
    import fpu_ss_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       set_valid,
    input  fpr_idx_t                   set_idx,
    input  logic                       clr_valid,
    input  fpr_idx_t                   clr_idx,
    input  fpr_idx_t [NUM_FPR_RS-1:0]  fpr_rs,
    input  logic [NUM_FPR_RS-1:0]      fpr_rs_use,
    input  fpr_idx_t                   rd,
    input  logic                       rd_is_fp,
    output logic                       hazard
);

    logic [NUM_FPR-1:0] pending;
    logic [NUM_FPR-1:0] set_mask;
    logic [NUM_FPR-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_valid) set_mask[set_idx] = 1'b1;
        if (clr_valid) clr_mask[clr_idx] = 1'b1;
    end

    // Set is OR-ed after the clear so a same-cycle issue/writeback to one
    // register leaves it pending (the new write is still outstanding).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pending <= '0;
        else       pending <= (pending & ~clr_mask) | set_mask;
    end

    always_comb begin
        hazard = rd_is_fp && pending[rd];
        for (int unsigned i = 0; i < NUM_FPR_RS; i++) begin
            if (fpr_rs_use[i] && pending[fpr_rs[i]]) hazard = 1'b1;
        end
    end

endmodule

// File: rtl/fpu_ss_offload_buffer.sv
// Offload request buffer for the FPU subsystem.
// Circular FIFO of DEPTH entries (any DEPTH >= 1) holding instruction word,
// NUM_RS integer operands of XLEN bits, FP source indices/use flags and the
// destination. No fall-through: a pushed entry is visible the next cycle.
// Optional macro FPU_SS_SCOREBOARD_EN adds an FP-register scoreboard that
// holds back the head entry while a register it touches has a write in
// flight; without it the block is a plain registered FIFO.
// Ports: clk_i, rst_i (async, active high); bus (slave modport of
// fpu_ss_offload_buffer_if) carrying flush, request, issue, writeback and
// usage signals.
module fpu_ss_offload_buffer
    import fpu_ss_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned NUM_RS = NUM_RS_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    fpu_ss_offload_buffer_if.slave bus
);

    localparam int unsigned USAGE_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [31:0]                 instr;
        logic [NUM_RS-1:0][XLEN-1:0] rs;
        fpr_idx_t [NUM_FPR_RS-1:0]   fpr_rs;
        logic [NUM_FPR_RS-1:0]       fpr_rs_use;
        fpr_idx_t                    rd;
        logic                        rd_is_fp;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    entry_t             wr_entry;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [USAGE_W-1:0] count;
    logic               full;
    logic               empty;
    logic               hazard;
    logic               out_valid;
    logic               push;
    logic               pop;

    // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == USAGE_W'(DEPTH));
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign out_valid = !empty && !hazard;
    assign push      = bus.in_valid_i && !full;
    assign pop       = out_valid && bus.out_ready_i;

    assign wr_entry = '{
        instr:      bus.in_instr_i,
        rs:         bus.in_rs_i,
        fpr_rs:     bus.in_fpr_rs_i,
        fpr_rs_use: bus.in_fpr_rs_use_i,
        rd:         bus.in_rd_i,
        rd_is_fp:   bus.in_rd_is_fp_i
    };

    assign bus.in_ready_o     = !full;
    assign bus.out_valid_o    = out_valid;
    assign bus.out_instr_o    = head.instr;
    assign bus.out_rs_o       = head.rs;
    assign bus.out_rd_o       = head.rd;
    assign bus.out_rd_is_fp_o = head.rd_is_fp;
    assign bus.usage_o        = count;

    // A pop in the flush cycle still counts (it reaches the scoreboard);
    // flush only discards what remains buffered and any concurrent push.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (push && !bus.flush_i) mem[wr_ptr] <= wr_entry;
    end

`ifdef FPU_SS_SCOREBOARD_EN
    fpu_ss_scoreboard u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_valid  (pop && head.rd_is_fp),
        .set_idx    (head.rd),
        .clr_valid  (bus.wb_valid_i),
        .clr_idx    (bus.wb_rd_i),
        .fpr_rs     (head.fpr_rs),
        .fpr_rs_use (head.fpr_rs_use),
        .rd         (head.rd),
        .rd_is_fp   (head.rd_is_fp),
        .hazard     (hazard)
    );
`else
    assign hazard = 1'b0;

    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{head.fpr_rs, head.fpr_rs_use, bus.wb_valid_i, bus.wb_rd_i};
`endif

endmodule

// File: tb/tb_fpu_ss_offload_buffer.sv
module tb_fpu_ss_offload_buffer;

`ifdef FPU_SS_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus, driven identically into a DEPTH=4 and a DEPTH=3 buffer.
    logic        flush, in_valid, out_ready, wb_valid, in_rd_is_fp;
    logic [31:0] in_instr;
    logic [95:0] in_rs;
    logic [14:0] in_fpr_rs;
    logic [2:0]  in_use;
    logic [4:0]  in_rd, wb_rd;

    fpu_ss_offload_buffer_if #(.DEPTH(4), .XLEN(32), .NUM_RS(3)) bus4 ();
    fpu_ss_offload_buffer_if #(.DEPTH(3), .XLEN(32), .NUM_RS(3)) bus3 ();

    assign bus4.flush_i = flush;            assign bus3.flush_i = flush;
    assign bus4.in_valid_i = in_valid;      assign bus3.in_valid_i = in_valid;
    assign bus4.in_instr_i = in_instr;      assign bus3.in_instr_i = in_instr;
    assign bus4.in_rs_i = in_rs;            assign bus3.in_rs_i = in_rs;
    assign bus4.in_fpr_rs_i = in_fpr_rs;    assign bus3.in_fpr_rs_i = in_fpr_rs;
    assign bus4.in_fpr_rs_use_i = in_use;   assign bus3.in_fpr_rs_use_i = in_use;
    assign bus4.in_rd_i = in_rd;            assign bus3.in_rd_i = in_rd;
    assign bus4.in_rd_is_fp_i = in_rd_is_fp; assign bus3.in_rd_is_fp_i = in_rd_is_fp;
    assign bus4.out_ready_i = out_ready;    assign bus3.out_ready_i = out_ready;
    assign bus4.wb_valid_i = wb_valid;      assign bus3.wb_valid_i = wb_valid;
    assign bus4.wb_rd_i = wb_rd;            assign bus3.wb_rd_i = wb_rd;

    fpu_ss_offload_buffer #(.DEPTH(4), .XLEN(32), .NUM_RS(3)) dut4 (
        .clk_i(clk), .rst_i(rst), .bus(bus4)
    );
    fpu_ss_offload_buffer #(.DEPTH(3), .XLEN(32), .NUM_RS(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .bus(bus3)
    );

    logic        d_ready [2];
    logic        d_valid [2];
    logic [2:0]  d_usage [2];
    logic [31:0] d_instr [2];
    logic [95:0] d_rs    [2];
    logic [4:0]  d_rd    [2];
    logic        d_rdfp  [2];

    assign d_ready[0] = bus4.in_ready_o;      assign d_ready[1] = bus3.in_ready_o;
    assign d_valid[0] = bus4.out_valid_o;     assign d_valid[1] = bus3.out_valid_o;
    assign d_usage[0] = bus4.usage_o;         assign d_usage[1] = 3'(bus3.usage_o);
    assign d_instr[0] = bus4.out_instr_o;     assign d_instr[1] = bus3.out_instr_o;
    assign d_rs[0]    = bus4.out_rs_o;        assign d_rs[1]    = bus3.out_rs_o;
    assign d_rd[0]    = bus4.out_rd_o;        assign d_rd[1]    = bus3.out_rd_o;
    assign d_rdfp[0]  = bus4.out_rd_is_fp_o;  assign d_rdfp[1]  = bus3.out_rd_is_fp_o;

    int npass  = 0;
    int ntotal = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [95:0] rs;
        logic [14:0] fpr_rs;
        logic [2:0]  fp_use;
        logic [4:0]  rd;
        logic        rd_is_fp;
    } req_t;

    req_t        mq [2][4];   // element 0 is the oldest request
    int          mcount [2];
    logic [31:0] mpend [2];
    int          mdepth [2] = '{4, 3};

    function automatic logic m_hazard(input int k);
        req_t h = mq[k][0];
        logic hz = 1'b0;
        if (SB) begin
            for (int i = 0; i < 3; i++)
                if (h.fp_use[i] && mpend[k][h.fpr_rs[i*5 +: 5]]) hz = 1'b1;
            if (h.rd_is_fp && mpend[k][h.rd]) hz = 1'b1;
        end
        return hz;
    endfunction

    function automatic logic m_valid(input int k);
        return (mcount[k] > 0) && !m_hazard(k);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcount[k] = 0;
            mpend[k]  = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic can_push, do_pop;
            can_push = in_valid && (mcount[k] < mdepth[k]);
            do_pop   = m_valid(k) && out_ready;
            if (wb_valid) mpend[k][wb_rd] = 1'b0;
            if (do_pop) begin
                if (mq[k][0].rd_is_fp) mpend[k][mq[k][0].rd] = 1'b1;
                for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i+1];
                mcount[k]--;
            end
            if (flush) mcount[k] = 0;
            else if (can_push) begin
                mq[k][mcount[k]] = {in_instr, in_rs, in_fpr_rs, in_use, in_rd, in_rd_is_fp};
                mcount[k]++;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("in_ready[d%0d]", mdepth[k]), 128'(d_ready[k]), 128'(mcount[k] < mdepth[k]));
            chk($sformatf("out_valid[d%0d]", mdepth[k]), 128'(d_valid[k]), 128'(m_valid(k)));
            chk($sformatf("usage[d%0d]", mdepth[k]), 128'(d_usage[k]), 128'(mcount[k]));
            if (m_valid(k)) begin
                chk($sformatf("out_instr[d%0d]", mdepth[k]), 128'(d_instr[k]), 128'(mq[k][0].instr));
                chk($sformatf("out_rs[d%0d]", mdepth[k]), 128'(d_rs[k]), 128'(mq[k][0].rs));
                chk($sformatf("out_rd[d%0d]", mdepth[k]), 128'(d_rd[k]), 128'(mq[k][0].rd));
                chk($sformatf("out_rd_is_fp[d%0d]", mdepth[k]), 128'(d_rdfp[k]), 128'(mq[k][0].rd_is_fp));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] instr, input logic [14:0] fr,
                           input logic [2:0] u, input logic [4:0] rd, input logic fp);
        in_valid    = 1'b1;
        in_instr    = instr;
        in_rs       = {instr ^ 32'hA5A5_0000, instr ^ 32'h0F0F_1234, ~instr};
        in_fpr_rs   = fr;
        in_use      = u;
        in_rd       = rd;
        in_rd_is_fp = fp;
    endtask

    task automatic wb_tick(input logic [4:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        flush = 0; in_valid = 0; out_ready = 0; wb_valid = 0; wb_rd = '0;
        set_req(32'h0, '0, '0, '0, 1'b0);
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset usage", 128'(bus4.usage_o), 128'd0);
        chk("reset in_ready", 128'(bus4.in_ready_o), 128'd1);
        chk("reset out_valid", 128'(bus4.out_valid_o), 128'd0);
        rst = 0;
        tick();

        // Fill with no pops: DEPTH=4 counts to 4, DEPTH=3 saturates at 3.
        for (int n = 1; n <= 4; n++) begin
            set_req(32'h100 + 32'(n), '0, '0, 5'(n), 1'b0);
            tick();
            chk($sformatf("fill usage4 n=%0d", n), 128'(bus4.usage_o), 128'(n));
            chk($sformatf("fill usage3 n=%0d", n), 128'(bus3.usage_o), 128'(n > 3 ? 3 : n));
        end
        chk("full in_ready4", 128'(bus4.in_ready_o), 128'd0);
        chk("full in_ready3", 128'(bus3.in_ready_o), 128'd0);
        set_req(32'h105, '0, '0, 5'd5, 1'b0);
        tick();
        chk("5th push rejected usage4", 128'(bus4.usage_o), 128'd4);
        chk("head after fill", 128'(bus4.out_instr_o), 128'h101);
        in_valid = 0;
        out_ready = 1;
        repeat (4) tick();
        chk("drained usage4", 128'(bus4.usage_o), 128'd0);
        chk("drained usage3", 128'(bus3.usage_o), 128'd0);

        // Streaming push+pop pairs: pointers wrap, occupancy stays at 1.
        for (int i = 0; i < 10; i++) begin
            set_req(32'h200 + 32'(i), '0, '0, 5'(i), 1'b0);
            tick();
            chk($sformatf("stream usage4 i=%0d", i), 128'(bus4.usage_o), 128'd1);
            chk($sformatf("stream usage3 i=%0d", i), 128'(bus3.usage_o), 128'd1);
            chk($sformatf("stream head3 i=%0d", i), 128'(bus3.out_instr_o), 128'(32'h200 + 32'(i)));
        end
        in_valid = 0;
        tick();
        chk("stream end usage3", 128'(bus3.usage_o), 128'd0);

        // RAW: A writes f5, B reads f5.
        out_ready = 0;
        set_req(32'h300, {5'd9, 5'd7, 5'd0}, 3'b000, 5'd5, 1'b1);
        tick();
        set_req(32'h301, {5'd9, 5'd7, 5'd5}, 3'b001, 5'd1, 1'b0);
        tick();
        in_valid = 0;
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("raw head instr", 128'(bus4.out_instr_o), 128'h301);
        chk("raw stall", 128'(bus4.out_valid_o), 128'(!SB));
        tick();
        chk("raw stall held", 128'(bus4.out_valid_o), 128'(!SB));
        wb_valid = 1; wb_rd = 5'd5;
        chk("raw stall in wb cycle", 128'(bus4.out_valid_o), 128'(!SB));
        tick();
        wb_valid = 0;
        chk("raw release after wb", 128'(bus4.out_valid_o), 128'd1);
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("raw drained", 128'(bus4.usage_o), 128'd0);

        // WAW on f7 and same-cycle set/clear of f9.
        set_req(32'h3FF, '0, '0, 5'd7, 1'b1); tick();
        set_req(32'h400, '0, '0, 5'd9, 1'b1); tick();
        set_req(32'h401, '0, '0, 5'd7, 1'b1); tick();
        in_valid = 0;
        out_ready = 1;
        tick();
        chk("waw head C", 128'(bus4.out_instr_o), 128'h400);
        chk("waw C valid", 128'(bus4.out_valid_o), 128'd1);
        wb_tick(5'd9);
        out_ready = 0;
        chk("waw head D", 128'(bus4.out_instr_o), 128'h401);
        chk("waw stall", 128'(bus4.out_valid_o), 128'(!SB));
        wb_tick(5'd7);
        chk("waw release", 128'(bus4.out_valid_o), 128'd1);
        set_req(32'h402, {5'd5, 5'd7, 5'd9}, 3'b001, 5'd2, 1'b0);
        out_ready = 1;
        tick();
        in_valid = 0;
        out_ready = 0;
        chk("f9 head E", 128'(bus4.out_instr_o), 128'h402);
        chk("f9 still pending", 128'(bus4.out_valid_o), 128'(!SB));
        wb_tick(5'd9);
        chk("f9 cleared, unused slot ignored", 128'(bus4.out_valid_o), 128'd1);
        out_ready = 1;
        tick();
        out_ready = 0;

        // Flush with concurrent push; f7 (set by D's issue) survives.
        for (int i = 0; i < 3; i++) begin
            set_req(32'h500 + 32'(i), '0, '0, 5'd3, 1'b0);
            tick();
        end
        chk("pre-flush usage4", 128'(bus4.usage_o), 128'd3);
        set_req(32'h5FF, '0, '0, 5'd3, 1'b0);
        flush = 1;
        tick();
        flush = 0;
        in_valid = 0;
        chk("flush usage4", 128'(bus4.usage_o), 128'd0);
        chk("flush usage3", 128'(bus3.usage_o), 128'd0);
        chk("flush out_valid", 128'(bus4.out_valid_o), 128'd0);
        chk("flush in_ready", 128'(bus4.in_ready_o), 128'd1);
        set_req(32'h600, {5'd0, 5'd0, 5'd7}, 3'b001, 5'd3, 1'b0);
        tick();
        in_valid = 0;
        chk("post-flush head", 128'(bus4.out_instr_o), 128'h600);
        chk("post-flush f7 pending", 128'(bus4.out_valid_o), 128'(!SB));
        wb_tick(5'd7);
        chk("post-flush release", 128'(bus4.out_valid_o), 128'd1);
        out_ready = 1;
        tick();
        out_ready = 0;

        // Asynchronous reset mid-operation.
        set_req(32'h700, '0, '0, 5'd1, 1'b0); tick();
        set_req(32'h701, '0, '0, 5'd1, 1'b0); tick();
        in_valid = 0;
        chk("pre-reset usage4", 128'(bus4.usage_o), 128'd2);
        #2 rst = 1;
        #1;
        chk("async reset usage4", 128'(bus4.usage_o), 128'd0);
        chk("async reset out_valid", 128'(bus4.out_valid_o), 128'd0);
        @(posedge clk);
        #1 rst = 0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/fpu_ss_offload_buffer.md
# fpu_ss_offload_buffer

Parametrised offload request buffer for the FPU subsystem. Sits between the C-request channel and the FPU subsystem's decoder/FPU issue stage. Holds offloaded requests (instruction word, integer operands, pre-decoded FP register indices) in a circular FIFO of configurable depth, XLEN and operand count. Adds an FP-register scoreboard that holds back the head request while any FP source or destination it touches still has a write in flight.

## Interface
- DEPTH, 4, FIFO entries; legal range ≥ 1, any value (not only powers of two).
- XLEN, 32, integer operand width.
- NUM_RS, 3, number of integer operands per request.
- USAGE_W, $clog2(DEPTH+1), derived; do not override.

- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous; discards all buffered entries.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  buffer can accept.
- in_instr_i  in  32  instruction word.
- in_rs_i  in  NUM_RS×XLEN  integer operands.
- in_fpr_rs_i  in  3×5  FP source register indices.
- in_fpr_rs_use_i  in  3  per-source "reads FP register" flag.
- in_rd_i  in  5  destination index.
- in_rd_is_fp_i  in  1  destination is an FP register.
- out_valid_o  out  1  head entry issuable.
- out_ready_i  in  1  issue stage accepts.
- out_instr_o, out_rs_o, out_rd_o, out_rd_is_fp_o  out  same widths as inputs  head entry fields.
- wb_valid_i  in  1  an FP register write completes this cycle.
- wb_rd_i  in  5  register being written.
- usage_o  out  USAGE_W  occupied entries.

## Operation
- The FIFO is a circular buffer with read and write pointers and an occupancy count.
  - Pointers wrap from DEPTH-1 to 0.
  - Full when count == DEPTH; empty when count == 0.
- Push: `in_valid_i && in_ready_o`, where `in_ready_o = !full`.
  - in_ready_o does not depend on out_ready_i, even when a pop happens in the same cycle.
- Pop: `out_valid_o && out_ready_i`.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Scoreboard: 32-bit pending vector, one bit per FP register.
  - Set: on a pop with out_rd_is_fp_o=1, bit out_rd_o is set.
  - Clear: on wb_valid_i, bit wb_rd_i is cleared.
  - Same bit set and cleared in one cycle: set wins.
- Hazard on the head entry:
  - any i with `in_fpr_rs_use[i] && pending[fpr_rs[i]]`, or
  - `rd_is_fp && pending[rd]` (WAW).
- `out_valid_o = !empty && !hazard`.
- Flush: count and both pointers go to 0 next cycle.
  - The scoreboard is not cleared, because in-flight operations still write back.
  - A push in the flush cycle is dropped; a pop in the flush cycle is still honoured (scoreboard set applies).
- Output data fields are driven from the head entry's storage regardless of valid.

## Timing
- Reset values:
  - in_ready_o=1, out_valid_o=0, usage_o=0.
  - Data outputs are the contents of entry 0; storage is not reset, so these are don't-care.
  - Pointers 0; pending vector all 0.
- No fall-through: a push into an empty buffer appears at out_valid_o on the next cycle. Minimum latency is 1 cycle.
- Scoreboard update has no bypass:
  - A set at issue blocks a dependent head from the following cycle.
  - A clear at writeback unblocks from the following cycle.
  - Back-to-back dependent requests therefore stall until wb_valid_i + 1 cycle.
- out_valid_o may deassert without a pop only through flush_i.
  - Once no hazard exists, out_valid_o holds until popped, because the scoreboard only gains bits via pops from this block.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); buffered entries are lost.

## Configuration
- FPU_SS_SCOREBOARD_EN defined:
  - Pending vector, hazard check and the wb_valid_i/wb_rd_i usage are present, as above.
- Not defined:
  - Scoreboard logic is removed; `out_valid_o = !empty`.
  - wb_* and in_fpr_rs_use_i are ignored; the block is a plain registered FIFO.

## Structure
- fpu_ss_pkg gains:
  - offload_entry_t, a packed struct of instr, rs[NUM_RS], fpr_rs[3], fpr_rs_use, rd, rd_is_fp, parametrised via XLEN_DEFAULT/NUM_RS_DEFAULT constants;
  - constant NUM_FPR=32.
- One sub-module: fpu_ss_scoreboard (pending vector, set/clear, hazard output), instantiated only under FPU_SS_SCOREBOARD_EN.

## Test plan
- Reset, then push 4 requests with DEPTH=4 and out_ready_i=0 -> usage_o counts 1..4; in_ready_o=0 after the 4th; a 5th in_valid_i is not accepted.
- DEPTH=3, 10 push/pop pairs with out_ready_i=1 -> pointers wrap; data pops in order; usage_o holds at 1 during steady state.
- Pop a request with rd=f5 (rd_is_fp=1), next head reads f5 -> out_valid_o=0; wb_valid_i with wb_rd_i=5 at cycle N -> out_valid_o=1 at N+1.
- Head has rd_is_fp=1, rd=f7 while f7 is pending -> stall (WAW); same-cycle pop setting f9 and wb clearing f9 -> f9 remains pending.
- 3 entries buffered, flush_i with a concurrent push -> usage_o=0 next cycle; pushed data never appears; the pending bit from the prior issue is still set.
- Macro undefined, dependent sequence as in scenario 3 -> no stall; out_valid_o=1 one cycle after push.
